// File: rtl/arb_pkg.sv
// Shared types and default sizing for the memory-bus arbiter
// and its round-robin picker.
package arb_pkg;

  localparam int NUM_CORES_DEF = 2;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after `last`,
// wrapping modulo NUM_CORES, wins. Also used by the snoop-bus arbiter.
module rr_pick import arb_pkg::*; #(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     win,
  output logic                 any
);

  localparam int unsigned NC = NUM_CORES;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      step);
    int unsigned sum;
    sum = 32'(base) + step;
    return IDX_W'((sum >= NC) ? (sum - NC) : sum);
  endfunction

  // Scan from the farthest offset to the nearest so the closest requester wins
  always_comb begin
    win = '0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      win = req[wrap_idx(last, i)] ? wrap_idx(last, i) : win;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between per-core cache controllers: round-robin
// grant, one outstanding transaction, write-invalidate snoop on every write.
module mem_bus_arbiter import arb_pkg::*; #(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             req,
  input  logic [NUM_CORES-1:0]             we,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_CORES-1:0][DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]             gnt,
  output logic [NUM_CORES-1:0]             done,
  output logic [DATA_W-1:0]                rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_ready,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             snoop_valid,
  output logic [ADDR_W-1:0]                snoop_addr,
  output logic [IDX_W-1:0]                 snoop_src
);

  localparam logic [NUM_CORES-1:0] ONE_LSB = {{(NUM_CORES-1){1'b0}}, 1'b1};

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_CORES-1:0]   r_gnt;
  logic [NUM_CORES-1:0]   r_done;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic                   r_snoop_valid;
  logic [ADDR_W-1:0]      r_snoop_addr;
  logic [IDX_W-1:0]       r_snoop_src;

  logic [IDX_W-1:0]       w_win;
  logic                   w_any;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req  (req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  // Transaction sequencer; every output is a register set here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last        <= IDX_W'(NUM_CORES - 1);
      r_gnt         <= '0;
      r_done        <= '0;
      r_rdata       <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_snoop_valid <= 1'b0;
      r_snoop_addr  <= '0;
      r_snoop_src   <= '0;
    end else begin
      r_mem_req     <= 1'b0;
      r_snoop_valid <= 1'b0;
      r_done        <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner       <= w_win;
            r_gnt         <= ONE_LSB << w_win;
            r_mem_req     <= 1'b1;
            r_mem_we      <= we[w_win];
            r_mem_addr    <= addr[w_win];
            r_mem_wdata   <= wdata[w_win];
            r_snoop_valid <= we[w_win];
            r_snoop_addr  <= we[w_win] ? addr[w_win] : r_snoop_addr;
            r_snoop_src   <= we[w_win] ? w_win : r_snoop_src;
            r_state       <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        // Memory may not answer in the issue cycle, so ready is not looked at
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            r_rdata <= mem_rdata;
            r_done  <= ONE_LSB << r_owner;
            r_state <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        DONE: begin
          r_gnt   <= '0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign snoop_valid = r_snoop_valid;
  assign snoop_addr  = r_snoop_addr;
  assign snoop_src   = r_snoop_src;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter; the bench also plays memory.
module tb_mem_bus_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NC-1:0]            req;
  logic [NC-1:0]            we;
  logic [NC-1:0][AW-1:0]    addr;
  logic [NC-1:0][DW-1:0]    wdata;
  logic [NC-1:0]            gnt;
  logic [NC-1:0]            done;
  logic [DW-1:0]            rdata;
  logic                     mem_req;
  logic                     mem_we;
  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_wdata;
  logic                     mem_ready;
  logic [DW-1:0]            mem_rdata;
  logic                     snoop_valid;
  logic [AW-1:0]            snoop_addr;
  logic [$clog2(NC)-1:0]    snoop_src;

  int          checks   = 0;
  int          failures = 0;
  int unsigned model_last;

  mem_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr),
    .snoop_src   (snoop_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_snoop_valid"}, 64'(snoop_valid), 64'd0);
    check({tag, "_snoop_addr"}, 64'(snoop_addr), 64'd0);
    check({tag, "_snoop_src"}, 64'(snoop_src), 64'd0);
  endtask

  // Round-robin rule: first requesting core after `last`, wrapping; NC = nobody
  function automatic int unsigned pick(input logic [NC-1:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= NC; k++) begin
      if (r[(last + k) % NC]) return (last + k) % NC;
    end
    return NC;
  endfunction

  // Called at the falling edge of an IDLE cycle with requests already driven;
  // returns at the falling edge of the following IDLE cycle.
  task automatic do_txn(input int lat, input logic [DW-1:0] rd, input bit spur,
                        input bit drop_mid, input bit rel_done);
    int unsigned   w;
    logic          xwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    logic [NC-1:0] oh;
    w = pick(req, model_last);
    if (w == NC) begin
      @(negedge clk);
      check("idle_gnt", 64'(gnt), 64'd0);
      check("idle_mem_req", 64'(mem_req), 64'd0);
      return;
    end
    xwe = we[w];
    xa  = addr[w];
    xd  = wdata[w];
    oh  = '0;
    oh[w] = 1'b1;
    @(negedge clk);
    check("issue_gnt", 64'(gnt), 64'(oh));
    check("issue_mem_req", 64'(mem_req), 64'd1);
    check("issue_mem_we", 64'(mem_we), 64'(xwe));
    check("issue_mem_addr", 64'(mem_addr), 64'(xa));
    check("issue_mem_wdata", 64'(mem_wdata), 64'(xd));
    check("issue_snoop_valid", 64'(snoop_valid), 64'(xwe));
    check("issue_done", 64'(done), 64'd0);
    if (xwe) begin
      check("issue_snoop_addr", 64'(snoop_addr), 64'(xa));
      check("issue_snoop_src", 64'(snoop_src), 64'(w));
    end
    mem_ready = spur;
    mem_rdata = $urandom;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check("wait_gnt", 64'(gnt), 64'(oh));
      check("wait_mem_req", 64'(mem_req), 64'd0);
      check("wait_snoop_valid", 64'(snoop_valid), 64'd0);
      check("wait_done", 64'(done), 64'd0);
      check("wait_mem_addr", 64'(mem_addr), 64'(xa));
      check("wait_mem_we", 64'(mem_we), 64'(xwe));
      if (drop_mid && i == 1) req[w] = 1'b0;
      for (int c = 0; c < NC; c++) begin
        if (c != int'(w)) begin
          addr[c]  = $urandom;
          wdata[c] = $urandom;
          we[c]    = 1'($urandom_range(0, 1));
        end
      end
      mem_ready = (i == lat);
      mem_rdata = (i == lat) ? rd : DW'($urandom);
    end
    @(negedge clk);
    check("done_done", 64'(done), 64'(oh));
    check("done_rdata", 64'(rdata), 64'(rd));
    check("done_gnt", 64'(gnt), 64'(oh));
    check("done_mem_req", 64'(mem_req), 64'd0);
    mem_ready  = 1'b0;
    model_last = w;
    if (rel_done) req[w] = 1'b0;
    @(negedge clk);
    check("post_gnt", 64'(gnt), 64'd0);
    check("post_done", 64'(done), 64'd0);
    check("post_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    reset      = 1'b0;
    req        = '0;
    we         = '0;
    addr       = '0;
    wdata      = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    model_last = NC - 1;
    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // single read from core 0
    we[0]   = 1'b0;
    addr[0] = 32'h0000_0100;
    req     = 2'b01;
    do_txn(2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);

    // write with snoop from core 1
    we[1]    = 1'b1;
    addr[1]  = 32'h0000_0200;
    wdata[1] = 32'h0000_CAFE;
    req      = 2'b10;
    do_txn(1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);

    // contention straight from reset: grants must alternate 0,1,0,1
    reset = 1'b0;
    #1;
    check_zero("reset2");
    @(negedge clk);
    reset      = 1'b1;
    model_last = NC - 1;
    we         = '0;
    addr[0]    = 32'h0000_0400;
    addr[1]    = 32'h0000_0500;
    req        = 2'b11;
    repeat (4) do_txn(1, DW'($urandom), 1'b0, 1'b0, 1'b0);

    // owner drops req mid-transaction; core 1 is next
    do_txn(2, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
    check("drop_req_vec", 64'(req), 64'h2);
    do_txn(1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b1);

    // spurious ready in IDLE and in ISSUE
    req       = '0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_idle_gnt", 64'(gnt), 64'd0);
      check("spur_idle_done", 64'(done), 64'd0);
      check("spur_idle_mem_req", 64'(mem_req), 64'd0);
    end
    mem_ready = 1'b0;
    we[0]     = 1'b1;
    wdata[0]  = 32'h0BAD_F00D;
    req       = 2'b01;
    do_txn(2, 32'h5555_AAAA, 1'b1, 1'b0, 1'b1);

    // reset during WAIT, leftover ready afterwards
    we[0]   = 1'b0;
    addr[0] = 32'h0000_0300;
    req     = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    mem_ready = 1'b1;
    @(negedge clk);
    check_zero("rst_hold");
    reset      = 1'b1;
    model_last = NC - 1;
    do_txn(3, 32'h0F0F_1234, 1'b1, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [NC-1:0] add;
      add = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        if (!req[c]) begin
          we[c]    = 1'($urandom_range(0, 1));
          addr[c]  = $urandom;
          wdata[c] = $urandom;
        end
      end
      req = req | add;
      do_txn($urandom_range(1, 4), DW'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and sequencer sharing one main-memory port between `NUM_CORES` per-core cache controllers in the multicore system. It serialises cache-miss refills and write-backs, issues one memory transaction at a time, and returns the result to the owning core. On every granted write it broadcasts a snoop so that the other cores' caches can invalidate the line.

## Interface
Parameters:
- `NUM_CORES`, 2: number of requesting cache controllers (≥2).
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width per transaction.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `req`  in  NUM_CORES  per-core request. Held high by the core until its `done` pulse.
- `we`  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- `addr`  in  NUM_CORES×ADDR_W  per-core address.
- `wdata`  in  NUM_CORES×DATA_W  per-core write data.
- `gnt`  out  NUM_CORES  one-hot. High for the owning core from ISSUE through DONE.
- `done`  out  NUM_CORES  one-hot, single-cycle completion pulse.
- `rdata`  out  DATA_W  read data, shared by all cores. Valid only while `done` is high.
- `mem_req`  out  1  memory request, single-cycle pulse.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DATA_W  memory command. Held stable from ISSUE until DONE.
- `mem_ready`  in  1  memory completion. Arrives at least 1 cycle after `mem_req`.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`.
- `snoop_valid`  out  1  write-invalidate broadcast, single-cycle pulse.
- `snoop_addr`  out  ADDR_W  address being written.
- `snoop_src`  out  $clog2(NUM_CORES)  index of the writing core. Other cores invalidate; the source ignores the snoop.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` bit is high, select the winner by round-robin, starting at `last+1` and wrapping modulo NUM_CORES.
  - Latch the winner's `we`/`addr`/`wdata` and its owner index, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `gnt[owner]`=1, `mem_req`=1.
  - If the latched `we`=1, also drive `snoop_valid`=1, `snoop_addr`=latched addr, `snoop_src`=owner.
  - Go to WAIT unconditionally.
- WAIT:
  - Hold `gnt` and the memory command.
  - When `mem_ready`=1, capture `mem_rdata` and go to DONE.
- DONE:
  - `done[owner]`=1 and `rdata` = captured data. For a write, `rdata` is the captured value, don't-care for the core.
  - Set `last` = owner and go to IDLE.
- Requests change only in IDLE. If an owner drops `req` mid-transaction, the transaction still completes and `done` still pulses.
- Changes on non-owner inputs during a transaction are ignored.
- `mem_ready` seen in ISSUE or IDLE is ignored, because memory protocol forbids it.
- Fairness: with all requests asserted continuously, grants rotate 0,1,…,N-1,0. No core waits more than NUM_CORES−1 transactions.

## Timing
- Reset values:
  - state = IDLE; `last` = NUM_CORES−1, so core 0 wins first.
  - `gnt`, `done`, `mem_req`, `mem_we`, `snoop_valid` = 0.
  - `mem_addr`, `mem_wdata`, `rdata`, `snoop_addr`, `snoop_src` = 0.
- Latency: `req` sampled in IDLE at edge t gives `gnt` and `mem_req` in cycle t+1.
- With `mem_ready` in cycle t+1+L (L≥1), `done` is high in cycle t+2+L. Minimum request-to-done is 3 cycles after sampling.
- Back-to-back: after DONE, IDLE lasts 1 cycle before the next ISSUE. Throughput is one transaction per L+3 cycles.
- All outputs are registered. No combinational path from any input to any output.
- Reset asserted mid-transaction: everything returns to reset values immediately and the outstanding memory access is abandoned. Memory shares the same reset.

## Structure
- Package `arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, ISSUE, WAIT, DONE);
  - the default constants NUM_CORES_DEF, ADDR_W_DEF, DATA_W_DEF.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`[NUM_CORES], `last` index.
  - Outputs: `win` index, `any` flag.
  - Reused by a later snoop-bus arbiter.
- The top level contains the FSM, the latches and the output registers.

## Test plan
- Single read: core0 read `addr`=0x100, memory returns 0xDEADBEEF with L=2 → `gnt[0]` for 4 cycles, `mem_we`=0, `done[0]` pulse with `rdata`=0xDEADBEEF, no `snoop_valid`.
- Write snoop: core1 writes 0xCAFE to 0x200 → `mem_we`=1 and `snoop_valid`=1 with `snoop_addr`=0x200, `snoop_src`=1 in the ISSUE cycle only, then `done[1]`.
- Contention: both cores request from reset, L=1, held for 4 transactions → grant order 0,1,0,1 and exactly one `gnt` bit high at any time.
- Request drop: core0 deasserts `req` during WAIT → `done[0]` still pulses and the next grant goes to core1 if it is requesting.
- Reset mid-transaction: `reset`=0 during WAIT → all outputs 0 immediately. After release, a core0 request is granted normally and `mem_ready` left over from the aborted access is ignored.
- Spurious ready: `mem_ready`=1 in IDLE and ISSUE → no state change, no `done`.
